// File: rtl/cpu_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cpu_dmem_responder
// Brief    : Fixed-latency word data memory for LW/SW with CPU stall handshake.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_dmem_responder #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic                    r_op_wr;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W-1:0]       r_rdata;
    logic [DATA_W-1:0]       r_mem [0:(1<<DEPTH_LOG2)-1];

    logic                    w_req;
    logic                    w_last;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_unused_addr;

    assign w_req         = MemRead ^ MemWrite;
    assign w_idx         = addr[DEPTH_LOG2:1];
    assign w_last        = (r_state == S_BUSY) && (r_cnt == 4'd0);
    // Byte-select bit and upper address bits wrap onto the word array.
    assign w_unused_addr = ^{addr[ADDR_W-1:DEPTH_LOG2+1], addr[0]};
    assign rdata         = r_rdata;

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_req;
                err   = MemRead & MemWrite;
                if (w_req) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (rst) begin
            stall = 1'b0;
            done  = 1'b0;
            err   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
            r_op_wr <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_req) begin
                r_op_wr <= MemWrite;
                r_idx   <= w_idx;
                r_wdata <= wdata;
                r_cnt   <= c_cnt_init;
            end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_last && !r_op_wr) begin
                r_rdata <= r_mem[r_idx];
            end
        end
    end

    // Array is not reset; a reset landing on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (w_last && r_op_wr && !rst) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cpu_dmem_responder
// Brief    : Self-checking bench: LATENCY=4 and LATENCY=1 instances vs timestamp model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_dmem_responder;

    localparam int c_lat0 = 4;
    localparam int c_lat1 = 1;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        mr  [2];
    logic        mw  [2];
    logic [15:0] ad  [2];
    logic [15:0] wd  [2];
    logic [15:0] rd_o[2];
    logic        st_o[2];
    logic        dn_o[2];
    logic        er_o[2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(c_lat0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .MemRead(mr[0]), .MemWrite(mw[0]), .addr(ad[0]),
        .wdata(wd[0]), .rdata(rd_o[0]), .stall(st_o[0]), .done(dn_o[0]), .err(er_o[0])
    );

    cpu_dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(c_lat1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .MemRead(mr[1]), .MemWrite(mw[1]), .addr(ad[1]),
        .wdata(wd[1]), .rdata(rd_o[1]), .stall(st_o[1]), .done(dn_o[1]), .err(er_o[1])
    );

    task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got %h want %h", nm, k, $time, act, exp);
        end
    endtask

    // Reference model: an accepted request at cycle t stalls through t+L,
    // commits at the end of t+L, and reports done in cycle t+L+1.
    int          cyc = 0;
    bit          m_init [2];
    bit          m_pend [2];
    int          m_t    [2];
    bit          m_opw  [2];
    int          m_idx  [2];
    logic [15:0] m_wd   [2];
    logic [15:0] m_rd   [2];
    bit          m_rk   [2];
    logic [15:0] m_mem  [2][1024];
    bit          m_mk   [2][1024];

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            int ph;
            int lat;
            bit rq, es, ed, ee;
            lat = (k == 0) ? c_lat0 : c_lat1;
            rq  = mr[k] ^ mw[k];
            ph  = cyc - m_t[k];
            es = 1'b0; ed = 1'b0; ee = 1'b0;
            if (!rst[k]) begin
                if (m_pend[k]) begin
                    es = (ph <= lat);
                    ed = (ph == lat + 1);
                end else begin
                    es = rq;
                    ee = mr[k] & mw[k];
                end
            end
            if (m_init[k]) begin
                chk("stall", k, {15'd0, st_o[k]}, {15'd0, es});
                chk("done",  k, {15'd0, dn_o[k]}, {15'd0, ed});
                chk("err",   k, {15'd0, er_o[k]}, {15'd0, ee});
                if (m_rk[k]) chk("rdata", k, rd_o[k], m_rd[k]);
            end
            if (rst[k]) begin
                m_init[k] = 1'b1;
                m_pend[k] = 1'b0;
                m_rd[k]   = 16'h0000;
                m_rk[k]   = 1'b1;
            end else if (m_pend[k]) begin
                if (ph == lat) begin
                    if (m_opw[k]) begin
                        m_mem[k][m_idx[k]] = m_wd[k];
                        m_mk[k][m_idx[k]]  = 1'b1;
                    end else begin
                        m_rd[k] = m_mem[k][m_idx[k]];
                        m_rk[k] = m_mk[k][m_idx[k]];
                    end
                end else if (ph == lat + 1) begin
                    m_pend[k] = 1'b0;
                end
            end else if (rq) begin
                m_pend[k] = 1'b1;
                m_t[k]    = cyc;
                m_opw[k]  = mw[k];
                m_idx[k]  = int'(ad[k][10:1]);
                m_wd[k]   = wd[k];
            end
        end
    end

    // Entered just after a rising edge; returns just after the edge ending DONE,
    // with the request still held so a caller can chain the next access.
    task automatic access(input int k, input bit w, input logic [15:0] a, input logic [15:0] d,
                          input int chg_at, input logic [15:0] ca, input logic [15:0] cd,
                          output int nst, output int ndone, output logic [15:0] r);
        mr[k] = !w; mw[k] = w; ad[k] = a; wd[k] = d;
        nst = 0; ndone = 0; r = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (st_o[k]) nst++;
            if (dn_o[k] && ndone == 0) begin
                ndone = i;
                r     = rd_o[k];
            end
            @(posedge clk); #1;
            if (ndone != 0) break;
            if (i == chg_at) begin
                ad[k] = ca;
                wd[k] = cd;
            end
        end
        if (ndone == 0) begin
            total++;
            bad++;
            $display("FAIL access_timeout dut%0d: got no done want done within 40 cycles", k);
        end
    endtask

    task automatic idle(input int k);
        mr[k] = 1'b0; mw[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic seq_lat4;
        int n, dn;
        logic [15:0] r;
        access(0, 1, 16'h0010, 16'hBEEF, 0, 0, 0, n, dn, r);
        chk("sw_stall_cycles", 0, 16'(n), 16'd5);
        chk("sw_done_cycle",   0, 16'(dn), 16'd6);
        access(0, 0, 16'h0010, 16'h0000, 0, 0, 0, n, dn, r);
        chk("lw_beef", 0, r, 16'hBEEF);
        chk("lw_done_cycle", 0, 16'(dn), 16'd6);
        access(0, 0, 16'h0011, 16'h0000, 0, 0, 0, n, dn, r);
        chk("lw_bit0_ignored", 0, r, 16'hBEEF);
        access(0, 1, 16'h0010, 16'h1234, 0, 0, 0, n, dn, r);
        access(0, 0, 16'h0810, 16'h0000, 0, 0, 0, n, dn, r);
        chk("lw_wrap", 0, r, 16'h1234);
        idle(0);
        mr[0] = 1'b1; mw[0] = 1'b1; ad[0] = 16'h0010; wd[0] = 16'hDEAD;
        @(negedge clk);
        chk("err_both", 0, {15'd0, er_o[0]}, 16'd1);
        chk("err_nostall", 0, {15'd0, st_o[0]}, 16'd0);
        @(posedge clk); #1;
        idle(0);
        chk("err_rdata_kept", 0, rd_o[0], 16'h1234);
        access(0, 0, 16'h0010, 16'h0000, 0, 0, 0, n, dn, r);
        chk("err_no_write", 0, r, 16'h1234);
        access(0, 1, 16'h0020, 16'h1111, 0, 0, 0, n, dn, r);
        idle(0);
        mw[0] = 1'b1; ad[0] = 16'h0020; wd[0] = 16'hAAAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[0] = 1'b1; mw[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("abort_stall", 0, {15'd0, st_o[0]}, 16'd0);
        chk("abort_rdata", 0, rd_o[0], 16'h0000);
        @(posedge clk); #1;
        access(0, 0, 16'h0020, 16'h0000, 0, 0, 0, n, dn, r);
        chk("abort_no_commit", 0, r, 16'h1111);
        access(0, 1, 16'h0040, 16'h7777, 0, 0, 0, n, dn, r);
        access(0, 1, 16'h0030, 16'h5555, 2, 16'h0040, 16'h9999, n, dn, r);
        access(0, 0, 16'h0030, 16'h0000, 0, 0, 0, n, dn, r);
        chk("captured_write", 0, r, 16'h5555);
        access(0, 0, 16'h0040, 16'h0000, 0, 0, 0, n, dn, r);
        chk("midbusy_ignored", 0, r, 16'h7777);
        idle(0);
    endtask

    task automatic seq_lat1;
        int n, dn;
        logic [15:0] r;
        access(1, 1, 16'h0010, 16'hCAFE, 0, 0, 0, n, dn, r);
        chk("l1_stall_cycles", 1, 16'(n), 16'd2);
        chk("l1_done_cycle",   1, 16'(dn), 16'd3);
        access(1, 0, 16'h0010, 16'h0000, 0, 0, 0, n, dn, r);
        chk("l1_lw", 1, r, 16'hCAFE);
        chk("l1_b2b_lw", 1, 16'(dn), 16'd3);
        access(1, 1, 16'h0012, 16'h0BAD, 0, 0, 0, n, dn, r);
        chk("l1_b2b_sw", 1, 16'(dn), 16'd3);
        access(1, 0, 16'h0012, 16'h0000, 0, 0, 0, n, dn, r);
        chk("l1_b2b_lw2", 1, 16'(dn), 16'd3);
        chk("l1_lw2", 1, r, 16'h0BAD);
        idle(1);
    endtask

    task automatic rand_run(input int k);
        for (int i = 0; i < 800; i++) begin
            rst[k] = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) begin
                int sel;
                sel = $urandom_range(0, 7);
                mr[k] = (sel <= 2) || (sel == 6);
                mw[k] = (sel >= 3 && sel <= 6);
                ad[k] = 16'($urandom);
                ad[k][10:5] = 6'd0;
                wd[k] = 16'($urandom);
            end
            @(posedge clk); #1;
        end
        rst[k] = 1'b0;
        idle(k);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = '0; wd[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_rdata", k, rd_o[k], 16'h0000);
            chk("reset_stall", k, {15'd0, st_o[k]}, 16'd0);
            chk("reset_done",  k, {15'd0, dn_o[k]}, 16'd0);
            chk("reset_err",   k, {15'd0, er_o[k]}, 16'd0);
        end
        @(posedge clk); #1;
        fork
            seq_lat4();
            seq_lat1();
        join
        fork
            rand_run(0);
            rand_run(1);
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
